// File: rtl/regfile_wb.sv
// Y86-64 SEQ register file with write-back stage: combinational operand reads,
// edge-triggered commit of valE/valM, status latch that freezes state on first fault.
module regfile_wb #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wb_valid,
  input  logic [3:0]       icode,
  input  logic [3:0]       rA,
  input  logic [3:0]       rB,
  input  logic             cnd,
  input  logic [63:0]      valE,
  input  logic [63:0]      valM,
  input  logic [2:0]       stat_in,
  output logic [63:0]      valA,
  output logic [63:0]      valB,
  input  logic [3:0]       dbg_addr,
  output logic [63:0]      dbg_data,
  output logic [2:0]       stat_out,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  localparam logic [3:0] I_CMOV  = 4'h2;
  localparam logic [3:0] I_IRMOV = 4'h3;
  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OPQ   = 4'h6;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;
  localparam logic [3:0] R_RSP   = 4'h4;
  localparam logic [3:0] R_NONE  = 4'hF;
  localparam logic [2:0] ST_AOK  = 3'd1;
  localparam logic [2:0] ST_HLT  = 3'd2;

  typedef enum logic {S_RUN, S_HALT} state_t;

  state_t            r_state;
  logic [2:0]        r_stat;
  logic [CNT_W-1:0]  r_retired;
  // Entry 15 is the "no register" slot: cleared on reset and never written, so reads of F yield 0.
  logic [63:0]       r_regs [0:15];

  logic [3:0]        w_src_a, w_src_b, w_dst_e, w_dst_m;
  logic              w_ret_sat;

  always_comb begin
    w_src_a = R_NONE;
    w_src_b = R_NONE;
    w_dst_e = R_NONE;
    w_dst_m = R_NONE;
    case (icode)
      I_CMOV:  begin w_src_a = rA; w_dst_e = cnd ? rB : R_NONE; end
      I_IRMOV: begin w_dst_e = rB; end
      I_RMMOV: begin w_src_a = rA; w_src_b = rB; end
      I_MRMOV: begin w_src_b = rB; w_dst_m = rA; end
      I_OPQ:   begin w_src_a = rA; w_src_b = rB; w_dst_e = rB; end
      I_CALL:  begin w_src_b = R_RSP; w_dst_e = R_RSP; end
      I_RET:   begin w_src_a = R_RSP; w_src_b = R_RSP; w_dst_e = R_RSP; end
      I_PUSH:  begin w_src_a = rA; w_src_b = R_RSP; w_dst_e = R_RSP; end
      I_POP:   begin w_src_a = R_RSP; w_src_b = R_RSP; w_dst_e = R_RSP; w_dst_m = rA; end
      default: ;
    endcase
  end

  assign valA      = r_regs[w_src_a];
  assign valB      = r_regs[w_src_b];
  assign dbg_data  = r_regs[dbg_addr];
  assign stat_out  = r_stat;
  assign halted    = (r_state == S_HALT);
  assign retired   = r_retired;
  assign w_ret_sat = &r_retired;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) r_regs[i] <= '0;
      r_state   <= S_RUN;
      r_stat    <= ST_AOK;
      r_retired <= '0;
    end else if (r_state == S_RUN && wb_valid) begin
      if (stat_in == ST_AOK) begin
        // dstM takes priority so popq %rsp keeps the loaded value.
        for (int i = 0; i < 15; i++) begin
          if (w_dst_m == i[3:0])      r_regs[i] <= valM;
          else if (w_dst_e == i[3:0]) r_regs[i] <= valE;
        end
        if (!w_ret_sat) r_retired <= r_retired + CNT_W'(1);
      end else begin
        r_stat  <= stat_in;
        r_state <= S_HALT;
        if (stat_in == ST_HLT && !w_ret_sat) r_retired <= r_retired + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb.sv
// Directed + random bench for regfile_wb against an architectural Y86 model;
// a second instance with a 4-bit counter exercises retired saturation.
module tb_regfile_wb;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_valid = 1'b0;
  logic [3:0]  icode = 4'h1, rA = 4'hF, rB = 4'hF, dbg_addr = 4'h0;
  logic        cnd = 1'b0;
  logic [63:0] valE = '0, valM = '0;
  logic [2:0]  stat_in = 3'd1;
  logic [63:0] valA, valB, dbg_data, valA4, valB4, dbg_data4;
  logic [2:0]  stat_out, stat_out4;
  logic        halted, halted4;
  logic [31:0] retired;
  logic [3:0]  retired4;

  int total = 0;
  int bad = 0;

  logic [63:0] m_regs [0:14];
  logic [2:0]  m_stat;
  bit          m_halt;
  int          m_cnt;

  always #5 clk = ~clk;

  regfile_wb #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .icode(icode), .rA(rA), .rB(rB),
    .cnd(cnd), .valE(valE), .valM(valM), .stat_in(stat_in), .valA(valA), .valB(valB),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .stat_out(stat_out), .halted(halted),
    .retired(retired));

  regfile_wb #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .icode(icode), .rA(rA), .rB(rB),
    .cnd(cnd), .valE(valE), .valM(valM), .stat_in(stat_in), .valA(valA4), .valB(valB4),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data4), .stat_out(stat_out4), .halted(halted4),
    .retired(retired4));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] src_a(input logic [3:0] ic, input logic [3:0] ra);
    if (ic == 4'h2 || ic == 4'h4 || ic == 4'h6 || ic == 4'hA) return ra;
    if (ic == 4'h9 || ic == 4'hB) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] src_b(input logic [3:0] ic, input logic [3:0] rb);
    if (ic == 4'h4 || ic == 4'h5 || ic == 4'h6) return rb;
    if (ic == 4'h8 || ic == 4'h9 || ic == 4'hA || ic == 4'hB) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] dst_e(input logic [3:0] ic, input logic [3:0] rb, input logic c);
    if (ic == 4'h2) return c ? rb : 4'hF;
    if (ic == 4'h3 || ic == 4'h6) return rb;
    if (ic == 4'h8 || ic == 4'h9 || ic == 4'hA || ic == 4'hB) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] dst_m(input logic [3:0] ic, input logic [3:0] ra);
    return (ic == 4'h5 || ic == 4'hB) ? ra : 4'hF;
  endfunction

  function automatic logic [63:0] mread(input logic [3:0] a);
    return (a == 4'hF) ? 64'd0 : m_regs[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 15; i++) m_regs[i] = '0;
    m_stat = 3'd1;
    m_halt = 0;
    m_cnt  = 0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".retired"}, 64'(retired), 64'(m_cnt));
    chk({tag, ".retired4"}, 64'(retired4), 64'((m_cnt > 15) ? 15 : m_cnt));
    chk({tag, ".stat"}, 64'(stat_out), 64'(m_stat));
    chk({tag, ".halted"}, 64'(halted), 64'(m_halt));
  endtask

  // Drive one instruction at negedge, check operands, commit at posedge, check state at next negedge.
  task automatic step(input string tag, input logic v, input logic [3:0] ic, input logic [3:0] ra,
                      input logic [3:0] rb, input logic c, input logic [63:0] ve,
                      input logic [63:0] vm, input logic [2:0] st);
    logic [3:0] de, dm, da;
    wb_valid = v; icode = ic; rA = ra; rB = rb; cnd = c; valE = ve; valM = vm; stat_in = st;
    #1;
    chk({tag, ".valA"}, valA, mread(src_a(ic, ra)));
    chk({tag, ".valB"}, valB, mread(src_b(ic, rb)));
    if (!m_halt && v) begin
      if (st == 3'd1) begin
        de = dst_e(ic, rb, c);
        dm = dst_m(ic, ra);
        if (de != 4'hF) m_regs[de] = ve;
        if (dm != 4'hF) m_regs[dm] = vm;
        m_cnt++;
      end else begin
        m_stat = st;
        m_halt = 1;
        if (st == 3'd2) m_cnt++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    wb_valid = 1'b0;
    da = 4'($urandom_range(0, 15));
    dbg_addr = da;
    #1;
    chk({tag, ".dbg"}, dbg_data, mread(da));
    check_state(tag);
    $display("step %s: icode=%h rA=%h rB=%h v=%0b st=%0d retired=%0d", tag, ic, ra, rb, v, st, retired);
  endtask

  task automatic check_reg(input string tag, input logic [3:0] a);
    dbg_addr = a;
    #1;
    chk(tag, dbg_data, mread(a));
  endtask

  task automatic do_reset();
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] ic;
    model_reset();
    do_reset();
    for (int i = 0; i < 16; i++) check_reg("reset.reg", 4'(i));
    check_state("reset");

    step("irmovq", 1, 4'h3, 4'hF, 4'h2, 0, 64'h1234, 64'h0, 3'd1);
    check_reg("irmovq.reg2", 4'h2);
    step("opq", 1, 4'h6, 4'h2, 4'h2, 0, 64'h2468, 64'h0, 3'd1);
    step("popq_rsp", 1, 4'hB, 4'h4, 4'hF, 0, 64'h100, 64'hBEEF, 3'd1);
    check_reg("popq.reg4", 4'h4);
    step("cmov_nc", 1, 4'h2, 4'h1, 4'h3, 0, 64'h5, 64'h0, 3'd1);
    check_reg("cmov.reg3", 4'h3);
    step("cmov_c", 1, 4'h2, 4'h4, 4'h3, 1, 64'h77, 64'h0, 3'd1);
    step("mrmovq", 1, 4'h5, 4'h7, 4'h2, 0, 64'h10, 64'hFFFF_0000_0000_0001, 3'd1);
    check_reg("mrmovq.reg7", 4'h7);
    step("novalid", 0, 4'h3, 4'hF, 4'h7, 0, 64'hDEAD, 64'h0, 3'd1);
    check_reg("novalid.reg7", 4'h7);
    step("illegal", 1, 4'hC, 4'h1, 4'h1, 1, 64'h99, 64'h98, 3'd1);

    for (int n = 0; n < 300; n++) begin
      ic = 4'($urandom_range(0, 15));
      step("rand", ($urandom_range(0, 3) != 0), ic, 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           {$urandom, $urandom}, {$urandom, $urandom}, 3'd1);
    end

    step("halt", 1, 4'h0, 4'hF, 4'hF, 0, 64'h0, 64'h0, 3'd2);
    step("after_halt", 1, 4'h3, 4'hF, 4'h1, 0, 64'h5555, 64'h0, 3'd1);
    check_reg("after_halt.reg1", 4'h1);

    // Mid-cycle asynchronous reset with a commit in flight.
    wb_valid = 1'b1; icode = 4'h3; rB = 4'h6; valE = 64'hABCD; stat_in = 3'd1;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_state("async_rst");
    check_reg("async_rst.reg4", 4'h4);
    @(posedge clk);
    @(negedge clk);
    check_reg("async_rst.reg6", 4'h6);
    wb_valid = 1'b0;
    rst_n = 1'b1;

    for (int n = 0; n < 20; n++)
      step("sat", 1, 4'h3, 4'hF, 4'(n % 15), 0, 64'(n + 1), 64'h0, 3'd1);

    step("adr", 1, 4'h6, 4'h1, 4'h2, 0, 64'hF00D, 64'h0, 3'd3);
    check_reg("adr.reg2", 4'h2);
    step("adr_frozen", 1, 4'h3, 4'hF, 4'h2, 0, 64'h1, 64'h0, 3'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
